// File: rtl/benes_pipe_net.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : benes_pipe_net                                                 |
// | Purpose : Pipelined SIZE-port Benes permutation network. Every beat      |
// |           carries its own switch settings down the pipe.                 |
// | Option  : BENES_PERF_CNT_EN adds beat_cnt / stall_cnt outputs.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module benes_pipe_net #(
  parameter int DATA_WIDTH = 64,
  parameter int LOG_N      = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [(DATA_WIDTH << LOG_N)-1:0]        in_data,
  input  logic [(2*LOG_N-1)*(1 << (LOG_N-1))-1:0] in_cfg,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [(DATA_WIDTH << LOG_N)-1:0]        out_data
`ifdef BENES_PERF_CNT_EN
  ,
  output logic [31:0]                             beat_cnt,
  output logic [31:0]                             stall_cnt
`endif
);

  localparam int SIZE   = 1 << LOG_N;
  localparam int STAGES = 2*LOG_N - 1;
  localparam int SW     = SIZE / 2;
  localparam int W      = SIZE * DATA_WIDTH;
  localparam int CW     = STAGES * SW;
  localparam int RCW    = CW - SW;

  // Destination port of local index p after the inter-stage wiring following stage s.
  function automatic int dest_idx(input int s, input int p);
    int b;
    int q;
    int base;
    if (s < LOG_N-1) b = SIZE >> s;
    else             b = SIZE >> (2*LOG_N-3-s);
    q    = p % b;
    base = p - q;
    if (s < LOG_N-1) return base + (q % 2) * (b / 2) + q / 2;
    else             return base + (q % (b / 2)) * 2 + q / (b / 2);
  endfunction

  logic [W-1:0]      data_q    [STAGES];
  logic [W-1:0]      data_d    [STAGES];
  logic [W-1:0]      stage_res [STAGES];
  logic [RCW-1:0]    cfg_q     [STAGES-1];
  logic [RCW-1:0]    cfg_d     [STAGES-1];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic [SW-1:0] c;

    if (s == 0) begin : g_first
      assign x = in_data;
      assign c = in_cfg[0 +: SW];
    end else begin : g_rest
      assign x = data_q[s-1];
      assign c = cfg_q[s-1][(s-1)*SW +: SW];
    end

    for (genvar j = 0; j < SW; j++) begin : g_sw
      assign y[2*j*DATA_WIDTH +: DATA_WIDTH]     = c[j] ? x[(2*j+1)*DATA_WIDTH +: DATA_WIDTH]
                                                        : x[2*j*DATA_WIDTH +: DATA_WIDTH];
      assign y[(2*j+1)*DATA_WIDTH +: DATA_WIDTH] = c[j] ? x[2*j*DATA_WIDTH +: DATA_WIDTH]
                                                        : x[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
    end

    if (s == STAGES-1) begin : g_out
      assign z = y;
    end else begin : g_wire
      for (genvar p = 0; p < SIZE; p++) begin : g_port
        assign z[dest_idx(s, p)*DATA_WIDTH +: DATA_WIDTH] = y[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign stage_res[s] = z;
  end

  // A stage may load when it is empty or when its occupant moves on.
  always_comb begin
    logic nxt;
    adv = '0;
    nxt = !valid_q[STAGES-1] || out_ready;
    adv[STAGES-1] = nxt;
    for (int s = STAGES-2; s >= 0; s--) begin
      nxt    = !valid_q[s] || nxt;
      adv[s] = nxt;
    end
  end

  assign in_ready  = adv[0] && !flush;
  assign out_valid = valid_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    cfg_d     = cfg_q;
    if (adv[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = stage_res[0];
      cfg_d[0]   = in_cfg[CW-1:SW];
    end
    for (int s = 1; s < STAGES; s++) begin
      if (adv[s]) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = stage_res[s];
      end
    end
    for (int s = 1; s < STAGES-1; s++) begin
      if (adv[s]) cfg_d[s] = cfg_q[s-1];
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < STAGES; s++)   data_q[s] <= '0;
      for (int s = 0; s < STAGES-1; s++) cfg_q[s]  <= '0;
    end else begin
      valid_q <= valid_d;
      for (int s = 0; s < STAGES; s++)   data_q[s] <= data_d[s];
      for (int s = 0; s < STAGES-1; s++) cfg_q[s]  <= cfg_d[s];
    end
  end

`ifdef BENES_PERF_CNT_EN
  logic [31:0] beat_cnt_q;
  logic [31:0] beat_cnt_d;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      beat_cnt_d  = '0;
      stall_cnt_d = '0;
    end else if (out_valid) begin
      if (out_ready) beat_cnt_d  = beat_cnt_q + 32'd1;
      else           stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign beat_cnt  = beat_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_benes_pipe_net.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_benes_pipe_net                                              |
// | Purpose : Self-checking bench for benes_pipe_net (4-port and 32-port).   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_benes_pipe_net;

  localparam int S_W  = 32;
  localparam int S_CW = 6;
  localparam int B_W  = 512;
  localparam int B_CW = 144;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [S_W-1:0]  s_in_data, s_out_data;
  logic [S_CW-1:0] s_in_cfg;
  logic            b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [B_W-1:0]  b_in_data, b_out_data;
  logic [B_CW-1:0] b_in_cfg;
`ifdef BENES_PERF_CNT_EN
  logic [31:0]     s_beat_cnt, s_stall_cnt, b_beat_cnt, b_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  benes_pipe_net #(.DATA_WIDTH(8), .LOG_N(2)) u_small (
    .clk(clk), .rst(rst), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_cfg(s_in_cfg),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data)
`ifdef BENES_PERF_CNT_EN
    , .beat_cnt(s_beat_cnt), .stall_cnt(s_stall_cnt)
`endif
  );

  benes_pipe_net #(.DATA_WIDTH(16), .LOG_N(5)) u_big (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_cfg(b_in_cfg),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef BENES_PERF_CNT_EN
    , .beat_cnt(b_beat_cnt), .stall_cnt(b_stall_cnt)
`endif
  );

  // Reference: apply each stage's swaps to a word array, then move words by
  // rotating the low k index bits (right = unshuffle, left = shuffle).
  function automatic logic [511:0] ref_perm(input int logn, input int dw,
                                            input logic [511:0] data, input logic [143:0] cfg);
    int size   = 1 << logn;
    int stages = 2*logn - 1;
    int half   = size / 2;
    int wmask  = (1 << dw) - 1;
    int cur [64];
    int nxt [64];
    int k, mask, low, nl, t;
    logic [511:0] tmp;
    logic [511:0] res;
    for (int p = 0; p < size; p++) begin
      tmp    = data >> (p*dw);
      cur[p] = int'(tmp[15:0]) & wmask;
    end
    for (int s = 0; s < stages; s++) begin
      for (int j = 0; j < half; j++) begin
        if (cfg[s*half + j]) begin
          t = cur[2*j]; cur[2*j] = cur[2*j+1]; cur[2*j+1] = t;
        end
      end
      if (s < stages-1) begin
        k    = (s < logn-1) ? (logn - s) : (s - logn + 3);
        mask = (1 << k) - 1;
        for (int p = 0; p < size; p++) begin
          low = p & mask;
          if (s < logn-1) nl = (low >> 1) | ((low & 1) << (k-1));
          else            nl = ((low << 1) & mask) | (low >> (k-1));
          nxt[(p & ~mask) | nl] = cur[p];
        end
        for (int p = 0; p < size; p++) cur[p] = nxt[p];
      end
    end
    res = '0;
    for (int p = 0; p < size; p++) res = res | (512'($unsigned(cur[p] & wmask)) << (p*dw));
    return res;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
    checks++; if (s_out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", s_out_data); end
    checks++; if (b_out_valid !== 1'b0 || b_out_data !== '0) begin
      failures++; $display("FAIL reset_big got_valid=%b exp=0 got_data=%h exp=0", b_out_valid, b_out_data); end
`ifdef BENES_PERF_CNT_EN
    checks++; if (s_beat_cnt !== 32'd0 || s_stall_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", s_beat_cnt, s_stall_cnt); end
`endif
  endtask

  task automatic test_latency(input string name, input logic [S_CW-1:0] cfg,
                              input logic [S_W-1:0] data, input logic [S_W-1:0] exp);
    next_cycle();
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = data;
    s_in_cfg    = cfg;
    #1;
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL %s_accept got=%b exp=1", name, s_in_ready); end
    next_cycle();
    s_in_valid = 1'b0;
    #1;
    for (int n = 1; n <= 3; n++) begin
      checks++;
      if (s_out_valid !== (n == 3)) begin
        failures++; $display("FAIL %s_latency cycle=%0d got=%b exp=%b", name, n, s_out_valid, (n == 3));
      end
      if (n == 3) begin
        checks++;
        if (s_out_data !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, s_out_data, exp); end
      end else begin
        next_cycle();
        #1;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [S_W-1:0] q[$];
    logic [S_W-1:0] prev_data;
    logic [511:0]   r;
    logic           prev_stall = 1'b0;
    logic           have = 1'b0;
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      next_cycle();
      s_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 10) begin
        if (!have) begin
          s_in_data = $urandom;
          s_in_cfg  = S_CW'($urandom_range(0, 63));
          have = 1'b1;
        end
        s_in_valid = 1'b1;
      end else begin
        s_in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== prev_data) begin
          failures++; $display("FAIL b2b_stall_hold got=%b/%h exp=1/%h", s_out_valid, s_out_data, prev_data);
        end
      end
      if (s_in_valid && s_in_ready) begin
        r = ref_perm(2, 8, 512'(s_in_data), 144'(s_in_cfg));
        q.push_back(r[31:0]);
        sent++;
        have = 1'b0;
      end
      if (s_out_valid && s_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_extra_beat got=%h exp=none", s_out_data);
        end else if (s_out_data !== q[0]) begin
          failures++; $display("FAIL b2b_data beat=%0d got=%h exp=%h", got, s_out_data, q[0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
        got++;
      end
      prev_stall = s_out_valid && !s_out_ready;
      prev_data  = s_out_data;
    end
    s_in_valid = 1'b0;
    checks++; if (got != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", got); end
  endtask

  task automatic test_flush();
    next_cycle();
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_in_data = $urandom;
      s_in_cfg  = S_CW'($urandom_range(0, 63));
      next_cycle();
    end
    #1;
    checks++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin
      failures++; $display("FAIL flush_full got_ready=%b exp=0 got_valid=%b exp=1", s_in_ready, s_out_valid); end
    s_flush = 1'b1;
    #1;
    checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", s_in_ready); end
    next_cycle();
    s_flush    = 1'b0;
    s_in_valid = 1'b0;
    #1;
    checks++; if (s_out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", s_out_valid); end
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready_after got=%b exp=1", s_in_ready); end
`ifdef BENES_PERF_CNT_EN
    checks++; if (s_beat_cnt !== 32'd0 || s_stall_cnt !== 32'd0) begin
      failures++; $display("FAIL flush_cnt got=%0d/%0d exp=0/0", s_beat_cnt, s_stall_cnt); end
`endif
    s_out_ready = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 5; i++) begin
        next_cycle();
        #1;
        if (s_out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL flush_ghost_beats got=%0d exp=0", seen); end
    end
  endtask

  task automatic test_reset_midstream();
    next_cycle();
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = 32'hA1B2C3D4;
    s_in_cfg    = '0;
    next_cycle();
    s_in_data   = 32'h55667788;
    next_cycle();
    s_in_valid  = 1'b0;
    next_cycle();
    #1;
    checks++; if (s_out_valid !== 1'b1) begin failures++; $display("FAIL mid_rst_inflight got=%b exp=1", s_out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (s_out_valid !== 1'b0 || s_out_data !== 32'h0) begin
      failures++; $display("FAIL mid_rst_outputs got=%b/%h exp=0/0", s_out_valid, s_out_data); end
    next_cycle();
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        next_cycle();
        #1;
        if (s_out_valid) seen++;
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL mid_rst_stale got=%0d exp=0", seen); end
    end
  endtask

`ifdef BENES_PERF_CNT_EN
  task automatic test_perf_counters();
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
      next_cycle();
      s_out_ready = (cyc >= 6);
      s_in_valid  = (sent < 5);
      s_in_data   = $urandom;
      s_in_cfg    = S_CW'($urandom_range(0, 63));
      #1;
      if (s_in_valid && s_in_ready) sent++;
      if (s_out_valid && s_out_ready) got++;
    end
    next_cycle();
    s_in_valid = 1'b0;
    #1;
    checks++; if (s_beat_cnt !== 32'd5) begin failures++; $display("FAIL perf_beat_cnt got=%0d exp=5", s_beat_cnt); end
    checks++; if (s_stall_cnt !== 32'd3) begin failures++; $display("FAIL perf_stall_cnt got=%0d exp=3", s_stall_cnt); end
  endtask
`endif

  task automatic test_random_big();
    logic [B_W-1:0] q[$];
    logic [B_W-1:0] prev_data;
    logic [159:0]   c160;
    logic           prev_stall = 1'b0;
    logic           have = 1'b0;
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
      next_cycle();
      b_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 40) begin
        if (!have) begin
          for (int i = 0; i < 16; i++) b_in_data[i*32 +: 32] = $urandom;
          for (int i = 0; i < 5; i++)  c160[i*32 +: 32] = $urandom;
          b_in_cfg = (sent == 0) ? '0 : c160[143:0];
          have = 1'b1;
        end
        b_in_valid = ($urandom_range(0, 4) != 0);
      end else begin
        b_in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== prev_data) begin
          failures++; $display("FAIL big_stall_hold got=%b/%h exp=1/%h", b_out_valid, b_out_data, prev_data);
        end
      end
      if (b_in_valid && b_in_ready) begin
        q.push_back(ref_perm(5, 16, b_in_data, b_in_cfg));
        sent++;
        have = 1'b0;
      end
      if (b_out_valid && b_out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL big_extra_beat got=%h exp=none", b_out_data);
        end else if (b_out_data !== q[0]) begin
          failures++; $display("FAIL big_data beat=%0d got=%h exp=%h", got, b_out_data, q[0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
        got++;
      end
      prev_stall = b_out_valid && !b_out_ready;
      prev_data  = b_out_data;
    end
    b_in_valid = 1'b0;
    checks++; if (got != 40) begin failures++; $display("FAIL big_count got=%0d exp=40", got); end
  endtask

  initial begin
    rst         = 1'b1;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_data   = '0;
    s_in_cfg    = '0;
    s_out_ready = 1'b1;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_cfg    = '0;
    b_out_ready = 1'b1;

    test_reset();
    test_latency("identity", 6'b000000, 32'h03020100, 32'h03020100);
    test_latency("pair_swap", 6'b000011, 32'h03020100, 32'h02030001);
    test_back_to_back();
    test_flush();
    test_reset_midstream();
`ifdef BENES_PERF_CNT_EN
    test_perf_counters();
`endif
    test_random_big();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
